// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the buart receiver and the CPU bus.
// Exposes a DATA word (pop on read) and a STATUS/CTRL word, plus a level-based irq.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned IRQ_LEVEL  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_rd,
  input  logic        sys_select,
  input  logic        sys_addr,
  input  logic        sys_rd,
  input  logic [3:0]  sys_we,
  input  logic [31:0] sys_wdata,
  output logic [31:0] sys_rdata,
  output logic        irq
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            overflow_q, overflow_d;
  logic            irq_en_q, irq_en_d;
  logic            rx_rd_q, rx_rd_d;
  logic            irq_q, irq_d;
  logic [7:0]      mem_q [DEPTH];

  logic            full, empty, push_try, push, pop, ctrl_wr, flush, ovf_set;
  logic [7:0]      head_byte;
  logic            unused_bits;

  assign full      = (level_q == LW'(DEPTH));
  assign empty     = (level_q == '0);
  assign ctrl_wr   = sys_select & sys_addr & sys_we[0];
  assign flush     = ctrl_wr & sys_wdata[1];
  assign push_try  = (state_q == IDLE) & rx_valid;
  // full is judged on the pre-pop level; a flush drops the byte silently
  assign push      = push_try & ~full & ~flush;
  assign ovf_set   = push_try & full & ~flush;
  assign pop       = sys_select & sys_rd & ~sys_addr & ~empty;
  assign head_byte = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign unused_bits = ^{sys_we[3:1], sys_wdata[31:3]};

  // Capture handshake: every byte is acknowledged, pushed or not
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rx_valid) state_d = ACK;
      ACK:     state_d = WAIT;
      WAIT:    if (!rx_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    irq_en_d   = irq_en_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
    if (ovf_set)                     overflow_d = 1'b1;
    else if (ctrl_wr & sys_wdata[0]) overflow_d = 1'b0;
    if (ctrl_wr) irq_en_d = sys_wdata[2];
    rx_rd_d = (state_d == ACK);
    irq_d   = irq_en_d & ((level_d >= LW'(IRQ_LEVEL)) | overflow_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      irq_en_q   <= 1'b0;
      rx_rd_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      irq_en_q   <= irq_en_d;
      rx_rd_q    <= rx_rd_d;
      irq_q      <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

  // Bus read mux; CPU samples the pre-pop head in the popping cycle
  always_comb begin
    sys_rdata = '0;
    if (sys_select) begin
      if (sys_addr) sys_rdata = {overflow_q, 22'b0, irq_en_q, 8'(level_q)};
      else          sys_rdata = {23'b0, ~empty, head_byte};
    end
  end

  assign rx_rd = rx_rd_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: bus reads queue their expected word,
// a negedge monitor pops and compares whenever a read strobe is presented.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_rd;
  logic        sys_select;
  logic        sys_addr;
  logic        sys_rd;
  logic [3:0]  sys_we;
  logic [31:0] sys_wdata;
  logic [31:0] sys_rdata;
  logic        irq;

  typedef struct {
    logic [31:0] v;
    string       n;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rd_pulses = 0;
  logic rd_prev = 1'b0;

  uart_rx_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_rd      (rx_rd),
    .sys_select (sys_select),
    .sys_addr   (sys_addr),
    .sys_rd     (sys_rd),
    .sys_we     (sys_we),
    .sys_wdata  (sys_wdata),
    .sys_rdata  (sys_rdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Monitor: read data against scoreboard, rx_rd pulse width and count
  always @(negedge clk) begin
    exp_t e;
    if (sys_select && sys_rd) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: read seen with no expectation, rdata %h", sys_rdata);
      end else begin
        e = exp_q.pop_front();
        if (sys_rdata !== e.v) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.n, sys_rdata, e.v);
        end
      end
    end
    if (rx_rd) begin
      checks++;
      rd_pulses++;
      if (rd_prev) begin
        errors++;
        $display("FAIL rx_rd_width: got 2+ cycles expected 1");
      end
    end
    rd_prev = rx_rd;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input logic [31:0] v, input string n);
    exp_t t;
    t.v = v;
    t.n = n;
    exp_q.push_back(t);
  endtask

  task automatic cpu_read(input logic a, input logic [31:0] v, input string n);
    sys_select = 1'b1;
    sys_addr   = a;
    sys_rd     = 1'b1;
    expect_rd(v, n);
    tick();
    sys_select = 1'b0;
    sys_rd     = 1'b0;
  endtask

  task automatic cpu_write(input logic [31:0] wd);
    sys_select = 1'b1;
    sys_addr   = 1'b1;
    sys_we     = 4'h1;
    sys_wdata  = wd;
    tick();
    sys_select = 1'b0;
    sys_we     = 4'h0;
    sys_wdata  = '0;
  endtask

  task automatic wait_ack();
    int n = 0;
    while (!rx_rd && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rx_rd_seen", 32'(rx_rd), 32'd1);
  endtask

  // Present a byte, hold until acknowledged, release, settle back to IDLE
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    wait_ack();
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  initial begin
    int p0;
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0;
    sys_select = 1'b0; sys_addr = 1'b0; sys_rd = 1'b0; sys_we = '0; sys_wdata = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_irq", 32'(irq), 32'd0);
    chk("reset_rx_rd", 32'(rx_rd), 32'd0);
    cpu_read(1'b1, 32'h0, "reset_status");
    cpu_read(1'b0, 32'h0, "reset_data");

    // 1: single byte
    p0 = rd_pulses;
    send(8'h41);
    chk("t1_pulses", 32'(rd_pulses - p0), 32'd1);
    cpu_read(1'b1, 32'h1, "t1_status");
    cpu_read(1'b0, 32'h141, "t1_data");
    cpu_read(1'b0, 32'h0, "t1_data_empty");

    // 2: overflow on the 17th byte
    p0 = rd_pulses;
    for (int i = 0; i < 17; i++) send(8'(i));
    chk("t2_pulses", 32'(rd_pulses - p0), 32'd17);
    cpu_read(1'b1, 32'h8000_0010, "t2_status_full");
    for (int i = 0; i < 16; i++) cpu_read(1'b0, 32'h100 | 32'(i), "t2_data");
    cpu_read(1'b0, 32'h0, "t2_data_empty");
    cpu_read(1'b1, 32'h8000_0000, "t2_status_ovf");
    cpu_write(32'h1);
    cpu_read(1'b1, 32'h0, "t2_ovf_cleared");

    // 3: irq follows level
    cpu_write(32'h4);
    chk("t3_irq_idle", 32'(irq), 32'd0);
    send(8'h55);
    chk("t3_irq_after_push", 32'(irq), 32'd1);
    cpu_read(1'b0, 32'h155, "t3_data");
    chk("t3_irq_after_pop", 32'(irq), 32'd0);
    cpu_write(32'h0);

    // 4: advance pointers to 14, then level 5 across the wrap, push+pop together
    for (int i = 0; i < 12; i++) begin
      send(8'h10 + 8'(i));
      cpu_read(1'b0, 32'h110 + 32'(i), "t4_filler");
    end
    for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i));
    cpu_read(1'b1, 32'h5, "t4_status_5");
    rx_valid = 1'b1; rx_data = 8'hB0;
    cpu_read(1'b0, 32'h1A0, "t4_concurrent_pop");
    wait_ack();
    tick();
    rx_valid = 1'b0;
    tick();
    cpu_read(1'b1, 32'h5, "t4_status_still_5");
    for (int i = 1; i < 5; i++) cpu_read(1'b0, 32'h1A0 + 32'(i), "t4_wrap_data");
    cpu_read(1'b0, 32'h1B0, "t4_last");
    cpu_read(1'b1, 32'h0, "t4_status_empty");

    // 5: full + concurrent push/pop, then clear+flush
    cpu_write(32'h4);
    chk("t5_irq_empty", 32'(irq), 32'd0);
    for (int i = 0; i < 16; i++) send(8'hC0 + 8'(i));
    chk("t5_irq_full", 32'(irq), 32'd1);
    cpu_read(1'b1, 32'h0000_0110, "t5_status_full");
    rx_valid = 1'b1; rx_data = 8'hDD;
    cpu_read(1'b0, 32'h1C0, "t5_concurrent_pop");
    wait_ack();
    tick();
    rx_valid = 1'b0;
    tick();
    cpu_read(1'b1, 32'h8000_010F, "t5_status_dropped");
    cpu_write(32'h3);
    chk("t5_irq_flushed", 32'(irq), 32'd0);
    cpu_read(1'b1, 32'h0, "t5_status_flushed");
    cpu_read(1'b0, 32'h0, "t5_data_flushed");

    // flush and push on the same edge: byte dropped, no overflow
    rx_valid = 1'b1; rx_data = 8'hEE;
    cpu_write(32'h2);
    wait_ack();
    tick();
    rx_valid = 1'b0;
    tick();
    cpu_read(1'b1, 32'h0, "flush_push_status");

    // 6: reset while in ACK
    rx_valid = 1'b1; rx_data = 8'h77;
    tick();
    chk("t6_in_ack", 32'(rx_rd), 32'd1);
    reset = 1'b1; rx_valid = 1'b0;
    tick();
    reset = 1'b0;
    chk("t6_rx_rd_dropped", 32'(rx_rd), 32'd0);
    cpu_read(1'b1, 32'h0, "t6_status");
    send(8'h78);
    cpu_read(1'b0, 32'h178, "t6_data_after_reset");

    repeat (3) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
